// File: rtl/openila_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : openila_capture_ctrl_if
// Purpose : Control, memory and readout signals of the ILA capture sequencer.
// Rev     : 1.0  initial release
// ============================================================================
interface openila_capture_ctrl_if #(
  parameter int W_MEM  = 9,
  parameter int W_ADDR = 8
);
  logic              arm;
  logic              abort;
  logic [W_ADDR-1:0] cfg_pretrig;
  logic              trigger;
  logic [W_MEM-1:0]  din;
  logic              din_valid;
  logic              capture_en;
  logic [W_ADDR-1:0] mem_addr;
  logic              mem_wen;
  logic [W_MEM-1:0]  mem_wdata;
  logic [W_MEM-1:0]  mem_rdata;
  logic              rd_req;
  logic [W_MEM-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              done;
  logic [2:0]        state;

  modport slave (
    input  arm, abort, cfg_pretrig, trigger, din, din_valid, mem_rdata, rd_req, rd_ready,
    output capture_en, mem_addr, mem_wen, mem_wdata, rd_data, rd_valid, done, state
  );

  modport master (
    output arm, abort, cfg_pretrig, trigger, din, din_valid, mem_rdata, rd_req, rd_ready,
    input  capture_en, mem_addr, mem_wen, mem_wdata, rd_data, rd_valid, done, state
  );
endinterface
`default_nettype wire

// File: rtl/openila_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : openila_capture_ctrl
// Purpose : Circular-buffer capture sequencer with pre-trigger window and
//           oldest-first valid/ready readout through a 2-entry skid buffer.
// Rev     : 1.0  initial release
// ============================================================================
module openila_capture_ctrl #(
  parameter int W_MEM  = 9,
  parameter int W_ADDR = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  openila_capture_ctrl_if.slave  ctrl
);

  localparam logic [W_ADDR:0]   c_DEPTH = {1'b1, {W_ADDR{1'b0}}};
  localparam logic [W_ADDR:0]   c_ONE_C = {{W_ADDR{1'b0}}, 1'b1};
  localparam logic [W_ADDR-1:0] c_ONE_A = {{(W_ADDR-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    c_IDLE    = 3'd0,
    c_PRETRIG = 3'd1,
    c_WAIT    = 3'd2,
    c_POST    = 3'd3,
    c_DONE    = 3'd4,
    c_READ    = 3'd5
  } state_t;

  state_t            r_state;
  logic [W_ADDR-1:0] r_wptr;
  logic [W_ADDR-1:0] r_pre;
  logic [W_ADDR:0]   r_fill;
  logic [W_ADDR:0]   r_post;
  logic [W_ADDR-1:0] r_start;
  logic [W_ADDR-1:0] r_raddr;
  logic [W_ADDR:0]   r_rcnt;
  logic [W_ADDR:0]   r_left;
  logic              r_pend;
  logic [1:0]        r_cnt;
  logic [W_MEM-1:0]  r_buf0;
  logic [W_MEM-1:0]  r_buf1;

  logic              w_capturing;
  logic              w_wen;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic [W_ADDR:0]   w_fill_nx;
  logic [W_ADDR:0]   w_post_init;

  assign w_capturing = (r_state == c_PRETRIG) || (r_state == c_WAIT) || (r_state == c_POST);
  assign w_wen       = ctrl.din_valid & w_capturing;
  assign w_pop       = (r_cnt != 2'd0) & ctrl.rd_ready;
  // Occupancy counts the word in flight from memory so the buffer never overflows.
  assign w_occ       = {1'b0, r_cnt} + {2'b00, r_pend};
  assign w_issue     = (r_state == c_READ) && (r_rcnt != '0) && (r_cnt != 2'd2)
                       && ((w_occ - {2'b00, w_pop}) < 3'd2);
  assign w_fill_nx   = r_fill + c_ONE_C;
  assign w_post_init = c_DEPTH - {1'b0, r_pre};

  assign ctrl.capture_en = w_capturing;
  assign ctrl.mem_wen    = w_wen;
  assign ctrl.mem_wdata  = ctrl.din;
  assign ctrl.mem_addr   = (r_state == c_READ) ? r_raddr : r_wptr;
  assign ctrl.rd_data    = r_buf0;
  assign ctrl.rd_valid   = (r_cnt != 2'd0);
  assign ctrl.done       = (r_state == c_DONE);
  assign ctrl.state      = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_wptr  <= '0;
      r_pre   <= '0;
      r_fill  <= '0;
      r_post  <= '0;
      r_start <= '0;
      r_raddr <= '0;
      r_rcnt  <= '0;
      r_left  <= '0;
      r_pend  <= 1'b0;
      r_cnt   <= 2'd0;
      r_buf0  <= '0;
      r_buf1  <= '0;
    end else begin
      if (w_wen) r_wptr <= r_wptr + c_ONE_A;

      if (r_pend && w_pop) begin
        if (r_cnt == 2'd1) begin
          r_buf0 <= ctrl.mem_rdata;
        end else begin
          r_buf0 <= r_buf1;
          r_buf1 <= ctrl.mem_rdata;
        end
      end else if (r_pend) begin
        if (r_cnt == 2'd0) r_buf0 <= ctrl.mem_rdata;
        else               r_buf1 <= ctrl.mem_rdata;
      end else if (w_pop) begin
        r_buf0 <= r_buf1;
      end
      r_cnt  <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
      r_pend <= w_issue;

      if (ctrl.abort) begin
        r_state <= c_IDLE;
        r_cnt   <= 2'd0;
        r_pend  <= 1'b0;
        r_rcnt  <= '0;
        r_left  <= '0;
      end else begin
        case (r_state)
          c_IDLE, c_DONE: begin
            if (ctrl.arm) begin
              r_pre   <= ctrl.cfg_pretrig;
              r_wptr  <= '0;
              r_fill  <= '0;
              r_state <= c_PRETRIG;
            end else if ((r_state == c_DONE) && ctrl.rd_req) begin
              r_raddr <= r_start;
              r_rcnt  <= c_DEPTH;
              r_left  <= c_DEPTH;
              r_state <= c_READ;
            end
          end
          c_PRETRIG: begin
            if (w_wen && (r_fill != c_DEPTH)) r_fill <= w_fill_nx;
            if ((r_pre == '0) || (ctrl.din_valid && (w_fill_nx == {1'b0, r_pre})))
              r_state <= c_WAIT;
          end
          c_WAIT: begin
            if (w_wen && (r_fill != c_DEPTH)) r_fill <= w_fill_nx;
            if (ctrl.trigger) begin
              // Oldest kept word sits pre entries behind the trigger word's slot.
              r_start <= r_wptr - r_pre;
              if (ctrl.din_valid) begin
                r_post  <= w_post_init - c_ONE_C;
                r_state <= (w_post_init == c_ONE_C) ? c_DONE : c_POST;
              end else begin
                r_post  <= w_post_init;
                r_state <= c_POST;
              end
            end
          end
          c_POST: begin
            if (ctrl.din_valid) begin
              r_post <= r_post - c_ONE_C;
              if (r_post == c_ONE_C) r_state <= c_DONE;
            end
          end
          c_READ: begin
            if (w_issue) begin
              r_raddr <= r_raddr + c_ONE_A;
              r_rcnt  <= r_rcnt - c_ONE_C;
            end
            if (w_pop) begin
              r_left <= r_left - c_ONE_C;
              if (r_left == c_ONE_C) begin
                r_state <= c_IDLE;
                r_cnt   <= 2'd0;
                r_pend  <= 1'b0;
              end
            end
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_openila_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_openila_capture_ctrl
// Purpose : Directed/random bench for openila_capture_ctrl against a
//           word-log reference model and a behavioural sample memory.
// Rev     : 1.0  initial release
// ============================================================================
module tb_openila_capture_ctrl;
  localparam int W_MEM  = 9;
  localparam int W_ADDR = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  openila_capture_ctrl_if #(.W_MEM(W_MEM), .W_ADDR(W_ADDR)) ifc ();
  openila_capture_ctrl #(.W_MEM(W_MEM), .W_ADDR(W_ADDR)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ifc)
  );

  logic [W_MEM-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ifc.mem_wen) mem[ifc.mem_addr] <= ifc.mem_wdata;
    ifc.mem_rdata <= mem[ifc.mem_addr];
  end

  int               n_checks = 0;
  int               n_err    = 0;
  logic [W_MEM-1:0] din_cnt;
  logic [W_ADDR-1:0] cfg;

  // Reference model: every word written since arm is kept in an unbounded log.
  logic [2:0]       m_st;
  int               m_pre, m_post, m_tidx, m_k, m_wcount;
  bit               m_tdv;
  logic [W_MEM-1:0] m_tdin;
  logic [W_MEM-1:0] m_log[$];
  logic [W_MEM-1:0] m_exp[$];
  bit               prev_stall;
  logic [W_MEM-1:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_err++;
    $error("FAIL timeout %s: model state %0d not reached in budget", tag, m_st);
  endtask

  task automatic wr();
    m_log.push_back(din_cnt);
    m_wcount++;
  endtask

  task automatic model_step(input bit arm, input bit abort, input bit trig, input bit dv,
                            input bit rdreq, input bit hs, input logic [W_MEM-1:0] rdata);
    if (abort) begin
      if (dv && (m_st inside {3'd1, 3'd2, 3'd3})) wr();
      m_st = 3'd0;
    end else begin
      case (m_st)
        3'd0, 3'd4: begin
          if (arm) begin
            m_pre = int'(cfg);
            m_log.delete();
            m_wcount = 0;
            m_st = 3'd1;
          end else if ((m_st == 3'd4) && rdreq) begin
            m_exp.delete();
            for (int i = 0; i < DEPTH; i++) m_exp.push_back(m_log[m_tidx - m_pre + i]);
            m_k  = 0;
            m_st = 3'd5;
          end
        end
        3'd1: begin
          if (dv) wr();
          if ((m_pre == 0) || (dv && (m_log.size() == m_pre))) m_st = 3'd2;
        end
        3'd2: begin
          if (trig) begin
            m_tidx = m_log.size();
            m_post = DEPTH - m_pre;
            m_tdv  = dv;
            m_tdin = din_cnt;
          end
          if (dv) wr();
          if (trig) begin
            if (dv) m_post--;
            m_st = (m_post == 0) ? 3'd4 : 3'd3;
          end
        end
        3'd3: begin
          if (dv) begin
            wr();
            m_post--;
            if (m_post == 0) m_st = 3'd4;
          end
        end
        3'd5: begin
          if (hs) begin
            chk("rd_data", rdata, m_exp[m_k]);
            if ((m_k == m_pre) && m_tdv) chk("trig_word", rdata, m_tdin);
            m_k++;
            if (m_k == DEPTH) m_st = 3'd0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit a_arm, input bit a_abort, input bit a_trig, input bit a_dv,
                     input bit a_rdreq, input bit a_ready);
    bit hs;
    ifc.arm         = a_arm;
    ifc.abort       = a_abort;
    ifc.trigger     = a_trig;
    ifc.din_valid   = a_dv;
    ifc.din         = din_cnt;
    ifc.rd_req      = a_rdreq;
    ifc.rd_ready    = a_ready;
    ifc.cfg_pretrig = cfg;
    #1;
    chk("state", ifc.state, m_st);
    chk("done", ifc.done, m_st == 3'd4);
    chk("capture_en", ifc.capture_en, m_st inside {3'd1, 3'd2, 3'd3});
    chk("mem_wen", ifc.mem_wen, a_dv && (m_st inside {3'd1, 3'd2, 3'd3}));
    chk("mem_wdata", ifc.mem_wdata, din_cnt);
    if (m_st != 3'd5) begin
      chk("rd_valid_idle", ifc.rd_valid, 1'b0);
      chk("mem_addr", ifc.mem_addr, m_wcount % DEPTH);
    end
    if (prev_stall) begin
      chk("hold_valid", ifc.rd_valid, 1'b1);
      chk("hold_data", ifc.rd_data, prev_data);
    end
    hs         = (m_st == 3'd5) && (ifc.rd_valid === 1'b1) && a_ready;
    prev_stall = (m_st == 3'd5) && (ifc.rd_valid === 1'b1) && !a_ready;
    prev_data  = ifc.rd_data;
    model_step(a_arm, a_abort, a_trig, a_dv, a_rdreq, hs, ifc.rd_data);
    @(posedge clk);
    if (a_dv) din_cnt++;
    #1;
  endtask

  function automatic bit dv_gen(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 2) == 0);
      default: return ($urandom_range(0, 1) == 1);
    endcase
  endfunction

  function automatic bit rdy_gen(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic run_until(input logic [2:0] st, input int budget, input int dv_mode,
                           input bit trig, input string tag);
    int n = 0;
    while ((m_st != st) && (n < budget)) begin
      cyc(1'b0, 1'b0, trig, dv_gen(dv_mode), 1'b0, 1'b0);
      n++;
    end
    if (m_st != st) timeout(tag);
  endtask

  task automatic readout(input int pct, input string tag);
    int n = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rdy_gen(pct));
    while ((m_st == 3'd5) && (n < 400)) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy_gen(pct));
      n++;
    end
    if (m_st != 3'd0) timeout(tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int mode;
    rst = 1'b1;
    ifc.arm = 1'b1; ifc.abort = 1'b0; ifc.trigger = 1'b1; ifc.din_valid = 1'b1;
    ifc.din = '0; ifc.rd_req = 1'b0; ifc.rd_ready = 1'b0; ifc.cfg_pretrig = '0;
    din_cnt = '0; cfg = '0; m_st = 3'd0; m_wcount = 0; m_pre = 0; m_post = 0;
    m_tidx = 0; m_k = 0; m_tdv = 1'b0; m_tdin = '0; prev_stall = 1'b0; prev_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", ifc.state, 3'd0);
    chk("rst_mem_addr", ifc.mem_addr, 4'd0);
    chk("rst_mem_wen", ifc.mem_wen, 1'b0);
    chk("rst_rd_valid", ifc.rd_valid, 1'b0);
    chk("rst_done", ifc.done, 1'b0);
    chk("rst_capture_en", ifc.capture_en, 1'b0);
    rst = 1'b0;

    // arm together with abort stays idle
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // 1: pre=4, trigger 6 cycles into WAIT
    cfg = 4'd4;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_until(3'd2, 30, 0, 1'b0, "s1_pretrig");
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_until(3'd4, 30, 0, 1'b0, "s1_post");
    readout(100, "s1_read");

    // 2: pre=0, trigger held from arm
    cfg = 4'd0;
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_until(3'd4, 40, 0, 1'b1, "s2_capture");
    readout(100, "s2_read");

    // 3: trigger only during PRETRIG, arm ignored in WAIT, later trigger
    cfg = 4'd8;
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_until(3'd2, 30, 0, 1'b1, "s3_pretrig");
    cfg = 4'd1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s3_no_done", ifc.done, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_until(3'd4, 30, 0, 1'b0, "s3_post");
    readout(50, "s3_read");

    // 4+5: sparse din_valid, long WAIT, random-ready readout
    cfg = 4'($urandom_range(1, 15));
    cyc(1'b1, 1'b0, 1'b0, dv_gen(1), 1'b0, 1'b0);
    run_until(3'd2, 200, 1, 1'b0, "s4_pretrig");
    repeat (120) cyc(1'b0, 1'b0, 1'b0, dv_gen(1), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, dv_gen(1), 1'b0, 1'b0);
    run_until(3'd4, 300, 1, 1'b0, "s4_post");
    readout(50, "s4_read");

    // 6: abort mid-POST, immediate re-arm with pre=2
    cfg = 4'd3;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_until(3'd2, 30, 0, 1'b0, "s6_pretrig");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg = 4'd2;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_until(3'd2, 30, 0, 1'b0, "s6_pretrig2");
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_until(3'd4, 30, 0, 1'b0, "s6_post");
    readout(50, "s6_read");

    // random full captures
    repeat (4) begin
      cfg  = 4'($urandom_range(0, 15));
      mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      cyc(1'b1, 1'b0, 1'b0, dv_gen(mode), 1'b0, 1'b0);
      run_until(3'd2, 200, mode, 1'b0, "rnd_pretrig");
      repeat ($urandom_range(0, 20)) cyc(1'b0, 1'b0, 1'b0, dv_gen(mode), 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, dv_gen(mode), 1'b0, 1'b0);
      run_until(3'd4, 300, mode, 1'b0, "rnd_post");
      readout($urandom_range(30, 100), "rnd_read");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
